sr_bank_writer: RTL and testbench

SR_BANK_WRITER -- requirements
Module: sr_bank_writer

---
 rtl/sr_pkg.sv | 28 ++
 rtl/sr_cell.sv | 27 ++
 rtl/sr_bank_writer.sv | 137 +++++++++++++
 tb/tb_sr_bank_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types and constants for the SR cell bank writer.
package sr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SET   = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4
  } sr_wr_state_t;

  localparam int SR_WIDTH_DEF  = 8;
  localparam int SR_SETTLE_MAX = 15;

  // Out-of-range settle requests saturate into 1..SR_SETTLE_MAX.
  function automatic logic [3:0] settle_clamp(input int settle);
    logic [3:0] res;
    if (settle < 1) begin
      res = 4'd1;
    end else if (settle > SR_SETTLE_MAX) begin
      res = 4'(SR_SETTLE_MAX);
    end else begin
      res = 4'(settle);
    end
    return res;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// Clocked SR flip-flop cell; the bank that sr_bank_writer drives is built from these.
module sr_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  output logic q
);

  logic q_r;

  // Set/reset storage; the illegal 11 excitation holds state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= 1'b0;
    end else begin
      case ({s, r})
        2'b10:   q_r <= 1'b1;
        2'b01:   q_r <= 1'b0;
        default: q_r <= q_r;
      endcase
    end
  end

  assign q = q_r;

endmodule

// File: rtl/sr_bank_writer.sv
// Writes a masked value into an external SR cell bank: clear pulse, set pulse,
// settle wait, then a readback check reported with a one-cycle done pulse.
module sr_bank_writer
  import sr_pkg::*;
#(
  parameter int WIDTH  = SR_WIDTH_DEF,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] req_mask,
  input  logic             abort,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [3:0] SETTLE_C = settle_clamp(SETTLE);

  sr_wr_state_t     state_r, next_s;
  logic [WIDTH-1:0] clr_vec_r, set_vec_r, data_r, mask_r;
  logic [WIDTH-1:0] clr_in_s, set_in_s, s_next_s, r_next_s;
  logic [WIDTH-1:0] s_r, r_r;
  logic [3:0]       cnt_r, cnt_next_s;
  logic             hs_s, done_r, err_r, done_next_s, err_next_s;

  // Next state, plus excitation/status for the upcoming cycle so they can be registered.
  always_comb begin
    next_s      = state_r;
    hs_s        = 1'b0;
    clr_in_s    = req_mask & ~req_data;
    set_in_s    = req_mask & req_data;
    s_next_s    = '0;
    r_next_s    = '0;
    done_next_s = 1'b0;
    err_next_s  = 1'b0;
    cnt_next_s  = 4'd0;

    if (abort) begin
      next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            hs_s = 1'b1;
            if (|clr_in_s) begin
              next_s = CLR;
            end else if (|set_in_s) begin
              next_s = SET;
            end else begin
              next_s = CHECK;
            end
          end else begin
            next_s = IDLE;
          end
        end
        CLR:     next_s = (|set_vec_r) ? SET : WAIT;
        SET:     next_s = WAIT;
        WAIT:    next_s = (cnt_r <= 4'd1) ? CHECK : WAIT;
        CHECK:   next_s = IDLE;
        default: next_s = IDLE;
      endcase
    end

    // Excitation follows the state being entered; a fresh handshake uses the live request.
    case (next_s)
      CLR:     r_next_s = hs_s ? clr_in_s : clr_vec_r;
      SET:     s_next_s = hs_s ? set_in_s : set_vec_r;
      CHECK: begin
        done_next_s = 1'b1;
        err_next_s  = hs_s ? 1'b0 : |((q_fb ^ data_r) & mask_r);
      end
      default: begin
        s_next_s = '0;
        r_next_s = '0;
      end
    endcase

    if (next_s == WAIT) begin
      if (state_r == WAIT) begin
        cnt_next_s = cnt_r - 4'd1;
      end else begin
        cnt_next_s = SETTLE_C;
      end
    end else begin
      cnt_next_s = 4'd0;
    end
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      s_r       <= '0;
      r_r       <= '0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      clr_vec_r <= '0;
      set_vec_r <= '0;
      data_r    <= '0;
      mask_r    <= '0;
    end else begin
      state_r <= next_s;
      cnt_r   <= cnt_next_s;
      s_r     <= s_next_s;
      r_r     <= r_next_s;
      done_r  <= done_next_s;
      err_r   <= err_next_s;
      if (hs_s) begin
        clr_vec_r <= clr_in_s;
        set_vec_r <= set_in_s;
        data_r    <= req_data;
        mask_r    <= req_mask;
      end else begin
        clr_vec_r <= clr_vec_r;
        set_vec_r <= set_vec_r;
        data_r    <= data_r;
        mask_r    <= mask_r;
      end
    end
  end

  assign s         = s_r;
  assign r         = r_r;
  assign done      = done_r;
  assign err       = err_r;
  assign busy      = (state_r != IDLE);
  assign req_ready = (state_r == IDLE);

endmodule

// File: tb/tb_sr_bank_writer.sv
// Self-checking bench: sr_bank_writer driving a bank of sr_cell instances,
// compared cycle by cycle against a timeline model built from the write rules.
module tb_sr_bank_writer;

  localparam int W  = 8;
  localparam int ST = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] req_data = '0;
  logic [W-1:0] req_mask = '0;
  logic [W-1:0] fault = '0;
  logic         req_ready, busy, done, err;
  logic [W-1:0] s, r, q_fb;
  wire  [W-1:0] q_bank;

  always #5 clk = ~clk;

  sr_bank_writer #(.WIDTH(W), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_mask(req_mask), .abort(abort),
    .s(s), .r(r), .q_fb(q_fb), .busy(busy), .done(done), .err(err)
  );

  for (genvar i = 0; i < W; i++) begin : g_bank
    sr_cell u_cell (.clk(clk), .rst_n(rst_n), .s(s[i]), .r(r[i]), .q(q_bank[i]));
  end

  assign q_fb = q_bank & ~fault;

  // One expected cycle of the writer's visible behaviour.
  typedef struct packed {
    logic         busy;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic         done;
  } cyc_t;

  cyc_t         model_q[$];
  cyc_t         cur = '0;
  logic [W-1:0] bank_m = '0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_mask = '0;
  logic         exp_err = 1'b0;
  int           checks = 0;
  int           failures = 0;
  int           cyc_cnt = 0;
  int           lat;
  int           ndone;
  logic         err_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Timeline of an accepted write: clear pulse, set pulse, settle, check.
  task automatic build_op(input logic [W-1:0] data, input logic [W-1:0] mask);
    logic [W-1:0] clr, set;
    cyc_t c;
    clr = mask & ~data;
    set = mask & data;
    m_data = data;
    m_mask = mask;
    if (clr != '0) begin c = '0; c.busy = 1'b1; c.r = clr; model_q.push_back(c); end
    if (set != '0) begin c = '0; c.busy = 1'b1; c.s = set; model_q.push_back(c); end
    if ((clr | set) != '0) begin
      for (int i = 0; i < ST; i++) begin c = '0; c.busy = 1'b1; model_q.push_back(c); end
    end
    c = '0; c.busy = 1'b1; c.done = 1'b1;
    model_q.push_back(c);
  endtask

  task automatic edge_step();
    @(posedge clk);
    cyc_cnt++;
    if (!rst_n) begin
      model_q.delete();
      cur = '0;
      bank_m = '0;
    end else begin
      bank_m = (bank_m | cur.s) & ~cur.r;
      if (cur.busy && abort) begin
        model_q.delete();
        cur = '0;
      end else if (!cur.busy && req_valid && !abort) begin
        build_op(req_data, req_mask);
        cur = model_q.pop_front();
      end else if (model_q.size() > 0) begin
        cur = model_q.pop_front();
      end else begin
        cur = '0;
      end
    end
    exp_err = cur.done ? |(((bank_m & ~fault) ^ m_data) & m_mask) : 1'b0;
    #1;
    check_eq("s", 32'(s), 32'(cur.s));
    check_eq("r", 32'(r), 32'(cur.r));
    check_eq("done", 32'(done), 32'(cur.done));
    check_eq("err", 32'(err), 32'(exp_err));
    check_eq("busy", 32'(busy), 32'(cur.busy));
    check_eq("req_ready", 32'(req_ready), 32'(!cur.busy));
    check_eq("s_and_r", 32'(s & r), 32'd0);
    check_eq("bank", 32'(q_bank), 32'(bank_m));
  endtask

  // Issue one request and wait (bounded) for done; lat counts cycles after the handshake edge.
  task automatic run_req(input logic [W-1:0] data, input logic [W-1:0] mask,
                         output int lat_o, output logic err_o);
    int hs;
    req_valid = 1'b1;
    req_data  = data;
    req_mask  = mask;
    edge_step();
    hs = cyc_cnt;
    req_valid = 1'b0;
    req_data  = ~data;
    req_mask  = ~mask;
    lat_o = -1;
    err_o = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        lat_o = cyc_cnt - hs + 1;
        err_o = err;
        break;
      end
      edge_step();
    end
    edge_step();
  endtask

  initial begin
    #2;
    check_eq("rst_s", 32'(s), 32'd0);
    check_eq("rst_r", 32'(r), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    edge_step();
    edge_step();
    @(negedge clk);
    rst_n = 1'b1;

    // Preset bank to 0x0F, then full write.
    run_req(8'h0F, 8'hFF, lat, err_seen);
    check_eq("preset_bank", 32'(q_bank), 32'h0F);
    run_req(8'hF0, 8'hFF, lat, err_seen);
    check_eq("full_lat", 32'(lat), 32'd4);
    check_eq("full_err", 32'(err_seen), 32'd0);
    check_eq("full_bank", 32'(q_bank), 32'hF0);

    run_req(8'hAA, 8'h0F, lat, err_seen);
    check_eq("partial_err", 32'(err_seen), 32'd0);
    check_eq("partial_bank", 32'(q_bank), 32'hFA);

    run_req(8'hFF, 8'h81, lat, err_seen);
    check_eq("setonly_lat", 32'(lat), 32'd3);
    check_eq("setonly_bank", 32'(q_bank), 32'hFB);

    run_req(8'h00, 8'h00, lat, err_seen);
    check_eq("nomask_lat", 32'(lat), 32'd1);
    check_eq("nomask_err", 32'(err_seen), 32'd0);

    fault = 8'h08;
    run_req(8'h08, 8'h08, lat, err_seen);
    check_eq("fault_err", 32'(err_seen), 32'd1);
    fault = '0;

    // Abort while in SET.
    req_valid = 1'b1; req_data = 8'h0F; req_mask = 8'hFF;
    edge_step();
    req_valid = 1'b0;
    edge_step();
    check_eq("set_phase_s", 32'(s), 32'h0F);
    abort = 1'b1;
    edge_step();
    abort = 1'b0;
    check_eq("abort_s", 32'(s), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      edge_step();
      if (done === 1'b1) ndone++;
    end
    check_eq("abort_no_done", 32'(ndone), 32'd0);
    run_req(8'h3C, 8'hFF, lat, err_seen);
    check_eq("post_abort_lat", 32'(lat), 32'd4);
    check_eq("post_abort_err", 32'(err_seen), 32'd0);

    // Abort coincident with a handshake in IDLE wins.
    req_valid = 1'b1; abort = 1'b1; req_data = 8'h11; req_mask = 8'hFF;
    edge_step();
    req_valid = 1'b0; abort = 1'b0;
    check_eq("abort_hs_busy", 32'(busy), 32'd0);

    // Reset while in WAIT.
    req_valid = 1'b1; req_data = 8'hFF; req_mask = 8'h81;
    edge_step();
    req_valid = 1'b0;
    edge_step();
    #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    cur = '0;
    bank_m = '0;
    check_eq("rstwait_busy", 32'(busy), 32'd0);
    check_eq("rstwait_done", 32'(done), 32'd0);
    check_eq("rstwait_s", 32'(s), 32'd0);
    check_eq("rstwait_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b1; req_data = 8'h55; req_mask = 8'hFF;
    edge_step();
    req_valid = 1'b0;
    check_eq("post_rst_hs", 32'(busy), 32'd1);
    for (int i = 0; i < 40 && cur.busy; i++) edge_step();

    // Randomized traffic with occasional aborts and feedback faults.
    for (int i = 0; i < 1500; i++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_data  = W'($urandom);
      req_mask  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      abort     = ($urandom_range(0, 19) == 0);
      fault     = ($urandom_range(0, 9) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
      edge_step();
    end
    req_valid = 1'b0;
    abort = 1'b0;
    fault = '0;
    for (int i = 0; i < 40 && cur.busy; i++) edge_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
